mem_port_arbiter3: RTL
======================

// Module: mem_port_arbiter3
// PURPOSE
//  Round-robin arbiter/sequencer sharing one memory/bus slave port among three requesters
//  (0 = instruction fetch, 1 = load/store unit, 2 = debug/DMA). Drives the 2-bit select of
//  the 3:1 request-path mux (encoding 00/01/10 = requester 0/1/2) and the slave handshake.
//  Grant is held for a burst of up to MAX_BEATS beats, then re-arbitrated if others wait.
// PARAMETERS
//  MAX_BEATS  8  max consecutive accepted beats per grant under contention (legal: >=1)
// PORTS
//  clk        in   1  clock, all state updates on rising edge
//  resetn     in   1  synchronous reset, active low
//  req        in   3  per-requester request; held high while requester has beats to send
//  s_ready    in   1  slave accepts current beat this cycle
//  s_valid    out  1  beat presented to slave = busy & req[sel]
//  sel        out  2  mux select / current grant index (00,01,10; 11 never driven)
//  gnt        out  3  one-hot grant, 3'b000 when not busy
//  ack        out  3  per-requester beat accepted = gnt[i] & s_valid & s_ready
//  busy       out  1  high in GRANT state
// BEHAVIOUR
//  Reset (resetn=0 at edge): state=IDLE, sel=2'b10 (last-granted=2, so 0 has top priority),
//   beat_cnt=0; gnt=000, s_valid=0, ack=000, busy=0 all combinationally from state.
//  States: IDLE, GRANT. sel is registered and held in IDLE (no mux glitch).
//  IDLE: if req!=0, pick first set bit scanning (sel+1),(sel+2),(sel+3) mod 3;
//   load sel, beat_cnt=0, go GRANT. Grant visible the cycle after req seen (1-cycle latency).
//   req==0: stay IDLE, sel unchanged.
//  GRANT: s_valid=req[sel]. Beat completes when s_valid&s_ready; beat_cnt++ (saturating).
//   Exit to IDLE when: (a) req[sel]==0, or (b) beat completes, beat_cnt==MAX_BEATS-1 and
//   any other req bit set. Else stay. Without contention the burst is unbounded.
//  Re-arbitration always passes through one IDLE cycle (1-cycle bubble between grants).
//  Round-robin guarantees: after release, the just-served requester has lowest priority.
//  Requester rule: req must not drop while s_valid&!s_ready; arbiter does not check this.
//  Requester must see ack to know a beat is done; data/addr muxed by sel, not by gnt.
//  Simultaneous: new req arriving in release cycle is considered in the following IDLE cycle.
//  beat_cnt width = $clog2(MAX_BEATS+1); MAX_BEATS=1 -> re-arbitrate after every beat when contended.
//  Reset mid-burst: returns IDLE same edge, in-flight beat abandoned (slave reset with it).
// TESTING
//  1 Reset: hold resetn=0 2 cycles -> sel=10, gnt=000, s_valid=0, busy=0.
//  2 req=001, s_ready=1 -> cycle+1 gnt=001, sel=00, ack[0] every cycle until req drops,
//    then IDLE next cycle.
//  3 req=111 held, s_ready=1, MAX_BEATS=8 -> grants 0,1,2,0 each for exactly 8 acks,
//    one idle cycle between grants.
//  4 req=011 with s_ready=0 -> gnt=001 holds indefinitely, no ack, no switch (beat not done).
//  5 Grant to 1, req[1] drops while req=101 -> next grant goes to 2 (rotation from 1), not 0.
//  6 resetn=0 mid-burst (gnt=010, beat_cnt=3) -> next cycle IDLE, sel=10, then req=010
//    regrants 1 with beat_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter3.sv
// mem_port_arbiter3
//   Round-robin arbiter sharing one slave port among three requesters
//   (0 = ifetch, 1 = lsu, 2 = debug/dma). A grant lasts for a burst of up to
//   MAX_BEATS accepted beats while other requesters are waiting. Without
//   contention the burst has no limit. There is always one IDLE cycle
//   between two grants.
// Ports
//   clk      rising-edge clock
//   resetn   synchronous reset, active low
//   req[2:0] per-requester request, held while beats remain
//   s_ready  slave accepts the presented beat this cycle
//   s_valid  beat presented to slave (busy & req[sel])
//   sel[1:0] registered mux select / grant index (00,01,10)
//   gnt[2:0] one-hot grant, 000 when idle
//   ack[2:0] per-requester beat accepted
//   busy     high while in GRANT
module mem_port_arbiter3 #(
  parameter int MAX_BEATS = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] req,
  input  logic       s_ready,
  output logic       s_valid,
  output logic [1:0] sel,
  output logic [2:0] gnt,
  output logic [2:0] ack,
  output logic       busy
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BEATS - 1);
  localparam logic [CW-1:0] SAT  = CW'(MAX_BEATS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sel_nxt, pick;
  logic [CW-1:0] beat_cnt, cnt_nxt;
  logic          beat_done, others;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      sel      <= 2'b10;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // First set request after the last grant, scanning sel+1, sel+2, sel+3 (mod 3).
  always_comb begin
    pick = sel;
    case (sel)
      2'b00:   pick = req[1] ? 2'b01 : req[2] ? 2'b10 : 2'b00;
      2'b01:   pick = req[2] ? 2'b10 : req[0] ? 2'b00 : 2'b01;
      default: pick = req[0] ? 2'b00 : req[1] ? 2'b01 : 2'b10;
    endcase
  end

  assign busy      = (state == GRANT);
  assign gnt       = busy ? (3'b001 << sel) : 3'b000;
  assign s_valid   = busy & req[sel];
  assign beat_done = s_valid & s_ready;
  assign ack       = gnt & {3{beat_done}};
  assign others    = |(req & ~(3'b001 << sel));

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          sel_nxt   = pick;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          state_nxt = IDLE;
        end else if (beat_done) begin
          if (beat_cnt != SAT) cnt_nxt = beat_cnt + 1'b1;
          // Past the burst limit on an uncontended burst the count sits at
          // SAT, so late contention still releases at the next beat.
          if (beat_cnt >= LAST && others) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
